// File: rtl/amber48_uart_tx_fifo.sv
// amber48_uart_tx_fifo: FIFO-buffered UART transmitter with per-frame configurable format and baud divisor
module amber48_uart_tx_fifo #(
  parameter int CLOCK_FREQ_HZ = 27_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int DIV_WIDTH     = 16,
  parameter int FIFO_DEPTH    = 16,
  localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [7:0]           data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 flush_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic [1:0]           cfg_dbits_i,
  input  logic [1:0]           cfg_parity_i,
  input  logic                 cfg_stop2_i,
  output logic [LVL_W-1:0]     level_o,
  output logic                 busy_o,
  output logic                 tx_o
);
  localparam int DEFAULT_DIV = (CLOCK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "FIFO_DEPTH must be a power of two >= 2");
  end
  if (DEFAULT_DIV < 1 || 64'(DEFAULT_DIV) >= (64'd1 << DIV_WIDTH)) begin : g_bad_div
    $fatal(1, "DEFAULT_DIV does not fit in DIV_WIDTH bits");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  state_e               state_q, state_d;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [LVL_W-1:0]     lvl_q;
  logic [DIV_WIDTH-1:0] cnt_q, div_q, div_eff;
  logic [7:0]           shift_q;
  logic [2:0]           bit_q, last_bit;
  logic [1:0]           dbits_q;
  logic                 par_en_q, par_bit_q, stop2_q;
  logic                 push, pop, tick, head_par;

  assign ready_o  = lvl_q != LVL_W'(FIFO_DEPTH);
  assign level_o  = lvl_q;
  assign push     = valid_i && ready_o && !flush_i;
  assign pop      = state_q == S_IDLE && lvl_q != '0 && !flush_i;
  assign tick     = cnt_q == '0;
  assign div_eff  = cfg_div_i == '0 ? DIV_WIDTH'(DEFAULT_DIV) : cfg_div_i;
  assign last_bit = {1'b0, dbits_q} + 3'd4;
  assign head_par = ^(mem_q[rd_q] & (8'hFF >> (2'd3 - cfg_dbits_i)));

  // FIFO pointers and occupancy; flush wins over any push or pop that cycle
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push);
      rd_q  <= rd_q + AW'(pop);
      lvl_q <= lvl_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // FIFO storage, no reset needed since occupancy gates every read
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= data_i;
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    state_q <= !rst_ni ? S_IDLE : state_d;
  end

  // FSM next state: each non-idle state advances only when the bit counter expires
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = pop ? S_START : S_IDLE;
      S_START: state_d = tick ? S_DATA : S_START;
      S_DATA:  state_d = tick && bit_q == last_bit ? (par_en_q ? S_PAR : S_STOP) : S_DATA;
      S_PAR:   state_d = tick ? S_STOP : S_PAR;
      S_STOP:  state_d = tick && (!stop2_q || bit_q[0]) ? S_IDLE : S_STOP;
      default: state_d = S_IDLE;
    endcase
  end

  // Frame datapath: capture byte and format on pop, then time bits and shift data out
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      div_q     <= '0;
      shift_q   <= '0;
      bit_q     <= '0;
      dbits_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (pop) begin
      shift_q   <= mem_q[rd_q];
      cnt_q     <= div_eff - DIV_WIDTH'(1);
      div_q     <= div_eff;
      dbits_q   <= cfg_dbits_i;
      par_en_q  <= ^cfg_parity_i;
      par_bit_q <= head_par ^ (cfg_parity_i == 2'b10);
      stop2_q   <= cfg_stop2_i;
      bit_q     <= '0;
    end else if (state_q != S_IDLE) begin
      cnt_q <= tick ? div_q - DIV_WIDTH'(1) : cnt_q - DIV_WIDTH'(1);
      if (tick && state_q == S_DATA) shift_q <= shift_q >> 1;
      if (tick) bit_q <= state_d == state_q ? bit_q + 3'd1 : 3'd0;
    end
  end

  // Line and busy outputs decoded from the registered state
  always_comb begin
    tx_o   = state_q == S_START ? 1'b0 :
             state_q == S_DATA  ? shift_q[0] :
             state_q == S_PAR   ? par_bit_q : 1'b1;
    busy_o = state_q != S_IDLE;
  end
endmodule
